// File: rtl/nn_load_sequencer.sv
// Load sequencer for one MNIST classification pass: packs row chunks into the image
// register, starts the classifier, waits for its result with a timeout, and latches the digit.
module nn_load_sequencer #(
  parameter int unsigned CHUNK_W    = 7,
  parameter int unsigned NUM_CHUNKS = 28,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_in_valid,
  input  logic [CHUNK_W-1:0]            i_in_data,
  input  logic                          i_abort,
  input  logic                          i_cls_done,
  input  logic [3:0]                    i_cls_digit,
  output logic [CHUNK_W*NUM_CHUNKS-1:0] o_image,
  output logic                          o_cls_start,
  output logic                          o_busy,
  output logic                          o_result_valid,
  output logic [3:0]                    o_digit,
  output logic                          o_error,
  output logic [4:0]                    o_load_count
);

  localparam int unsigned TimerW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StStart, StWait} state_e;

  state_e                          r_state;
  logic [CHUNK_W*NUM_CHUNKS-1:0]   r_image;
  logic [4:0]                      r_load_count;
  logic [TimerW-1:0]               r_timer;
  logic                            r_result_valid;
  logic [3:0]                      r_digit;
  logic                            r_error;
  logic                            w_last_chunk;
  logic                            w_timeout;

  assign w_last_chunk = (r_load_count == 5'(NUM_CHUNKS - 1));
  // Last WAIT cycle: timer would reach TIMEOUT on this edge.
  assign w_timeout    = (r_timer == TimerW'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= StIdle;
      r_image        <= '0;
      r_load_count   <= '0;
      r_timer        <= '0;
      r_result_valid <= 1'b0;
      r_digit        <= '0;
      r_error        <= 1'b0;
    end else if (i_abort) begin
      r_state        <= StIdle;
      r_load_count   <= '0;
      r_result_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_in_valid) begin
            r_image[CHUNK_W-1:0] <= i_in_data;
            r_load_count         <= 5'd1;
            r_result_valid       <= 1'b0;
            r_error              <= 1'b0;
            r_state              <= (NUM_CHUNKS == 1) ? StStart : StLoad;
          end
        end
        StLoad: begin
          if (i_in_valid) begin
            r_image[int'(r_load_count)*CHUNK_W +: CHUNK_W] <= i_in_data;
            r_load_count <= r_load_count + 5'd1;
            if (w_last_chunk) r_state <= StStart;
          end
        end
        StStart: begin
          r_timer <= '0;
          r_state <= StWait;
        end
        StWait: begin
          if (i_cls_done) begin
            r_digit        <= i_cls_digit;
            r_result_valid <= 1'b1;
            r_error        <= (i_cls_digit > 4'd9);
            r_load_count   <= '0;
            r_state        <= StIdle;
          end else if (w_timeout) begin
            r_digit        <= 4'hE;
            r_result_valid <= 1'b0;
            r_error        <= 1'b1;
            r_load_count   <= '0;
            r_state        <= StIdle;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_image        = r_image;
  assign o_cls_start    = (r_state == StStart);
  assign o_busy         = (r_state != StIdle);
  assign o_result_valid = r_result_valid;
  assign o_digit        = r_digit;
  assign o_error        = r_error;
  assign o_load_count   = r_load_count;

endmodule

// File: tb/tb_nn_load_sequencer.sv
// Directed bench for nn_load_sequencer: expected results go into a scoreboard queue when
// classifier responses are driven and are checked when the sequencer returns to idle.
module tb_nn_load_sequencer;

  localparam int NC = 28;
  localparam int TO = 1023;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [6:0]   in_data = '0;
  logic         abort = 1'b0;
  logic         cls_done = 1'b0;
  logic [3:0]   cls_digit = '0;
  logic [195:0] image;
  logic         cls_start;
  logic         busy;
  logic         result_valid;
  logic [3:0]   digit;
  logic         error;
  logic [4:0]   load_count;

  typedef struct packed {
    logic [3:0] dig;
    logic       rv;
    logic       err;
  } res_t;

  res_t         sb[$];
  int           total = 0;
  int           bad = 0;
  logic [195:0] exp_img = '0;
  int           exp_lc = 0;
  int           ncyc;

  nn_load_sequencer dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_in_valid     (in_valid),
    .i_in_data      (in_data),
    .i_abort        (abort),
    .i_cls_done     (cls_done),
    .i_cls_digit    (cls_digit),
    .o_image        (image),
    .o_cls_start    (cls_start),
    .o_busy         (busy),
    .o_result_valid (result_valid),
    .o_digit        (digit),
    .o_error        (error),
    .o_load_count   (load_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [195:0] obs, input logic [195:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_chunk(input logic [6:0] d);
    in_valid = 1'b1;
    in_data  = d;
    exp_img[exp_lc*7 +: 7] = d;
    exp_lc++;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic full_load(input logic [6:0] base);
    exp_lc = 0;
    for (int k = 0; k < NC; k++) load_chunk(base + 7'(k));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_image"}, image, '0);
    chk({tag, "_lc"}, load_count, 0);
    chk({tag, "_start"}, cls_start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rv"}, result_valid, 0);
    chk({tag, "_digit"}, digit, 0);
    chk({tag, "_err"}, error, 0);
  endtask

  // Bounded wait for idle, then pop the expected result and compare.
  task automatic wait_result(input string tag, output int n);
    res_t e;
    n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_sbsize"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_digit"}, digit, e.dig);
      chk({tag, "_rv"}, result_valid, e.rv);
      chk({tag, "_err"}, error, e.err);
      chk({tag, "_lc"}, load_count, 0);
    end
  endtask

  task automatic respond(input logic [3:0] d, input logic exp_err);
    cls_done  = 1'b1;
    cls_digit = d;
    sb.push_back('{dig: d, rv: 1'b1, err: exp_err});
    tick();
    cls_done = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    check_reset("rst0");

    // Consecutive full load 1..28
    full_load(7'h01);
    chk("t1_img_lo", image[6:0], 7'h01);
    chk("t1_img_hi", image[195:189], 7'h1C);
    chk("t1_img", image, exp_img);
    chk("t1_lc", load_count, 28);
    chk("t1_start", cls_start, 1);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_start_once", cls_start, 0);
    chk("t1_busy_wait", busy, 1);

    // Result digit 7, three cycles after cls_start
    tick();
    tick();
    respond(4'd7, 1'b0);
    wait_result("t2", ncyc);
    exp_lc = 0;
    load_chunk(7'h11);
    chk("t2_rv_clr", result_valid, 0);
    chk("t2_lc1", load_count, 1);
    chk("t2_busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t2_ab_lc", load_count, 0);
    chk("t2_ab_busy", busy, 0);
    chk("t2_ab_digit", digit, 7);

    // Gapped load, abort colliding with chunk 11
    exp_lc = 0;
    for (int k = 0; k < 10; k++) begin
      load_chunk(7'h40 + 7'(k));
      tick();
      tick();
    end
    chk("t3_lc10", load_count, 10);
    in_valid = 1'b1;
    in_data  = 7'h7F;
    abort    = 1'b1;
    tick();
    in_valid = 1'b0;
    abort    = 1'b0;
    chk("t3_lc", load_count, 0);
    chk("t3_busy", busy, 0);
    chk("t3_rv", result_valid, 0);
    chk("t3_img", image, exp_img);
    full_load(7'h20);
    chk("t3_img2", image, exp_img);
    tick();
    respond(4'd3, 1'b0);
    wait_result("t3r", ncyc);

    // Timeout: TIMEOUT cycles in WAIT after the START cycle
    full_load(7'h05);
    sb.push_back('{dig: 4'hE, rv: 1'b0, err: 1'b1});
    wait_result("t4", ncyc);
    chk("t4_cycles", ncyc, TO + 1);

    // Out-of-range digit; cls_done during START is ignored
    exp_lc = 0;
    load_chunk(7'h33);
    chk("t5_err_clr", error, 0);
    chk("t5_digit_hold", digit, 4'hE);
    for (int k = 1; k < NC; k++) load_chunk(7'h33 + 7'(k));
    chk("t5_start", cls_start, 1);
    cls_done  = 1'b1;
    cls_digit = 4'd5;
    tick();
    cls_done = 1'b0;
    chk("t5_ign_busy", busy, 1);
    chk("t5_ign_rv", result_valid, 0);
    tick();
    respond(4'd12, 1'b1);
    wait_result("t5", ncyc);

    // cls_done on the final WAIT cycle beats the timeout
    full_load(7'h44);
    for (int k = 0; k < TO; k++) tick();
    chk("t5b_busy", busy, 1);
    respond(4'd9, 1'b0);
    wait_result("t5b", ncyc);

    // abort beats cls_done in the same cycle
    full_load(7'h0A);
    tick();
    cls_done  = 1'b1;
    cls_digit = 4'd2;
    abort     = 1'b1;
    tick();
    cls_done = 1'b0;
    abort    = 1'b0;
    chk("t5c_busy", busy, 0);
    chk("t5c_rv", result_valid, 0);
    chk("t5c_digit", digit, 9);
    chk("t5c_lc", load_count, 0);

    // rst mid-LOAD
    exp_lc = 0;
    for (int k = 0; k < 15; k++) load_chunk(7'h61 + 7'(k));
    chk("t6_lc15", load_count, 15);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("t6a");
    exp_img = '0;
    exp_lc  = 0;
    load_chunk(7'h55);
    chk("t6_img", image, exp_img);
    chk("t6_lc1", load_count, 1);

    // rst in WAIT
    for (int k = 1; k < NC; k++) load_chunk(7'h01 + 7'(k));
    tick();
    chk("t6_wait", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("t6b");
    tick();
    chk("t6_nostart", cls_start, 0);
    exp_img = '0;
    exp_lc  = 0;
    load_chunk(7'h2A);
    chk("t6_img2", image, exp_img);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nn_load_sequencer.md
Name: nn_load_sequencer

Overview:
Controls one image-classification pass of the 14x14 MNIST accelerator.
- Assembles 28 seven-bit row chunks from the pin interface into a 196-bit image register.
- Fires the classifier core, waits for its done strobe with a timeout, and latches the BCD digit for the seven-segment driver.
- Sits between the top-level pin wrapper and the classifier datapath.

Parameters:
CHUNK_W, 7, bits per input chunk
NUM_CHUNKS, 28, chunks per image (CHUNK_W*NUM_CHUNKS = 196 image bits)
TIMEOUT, 1023, maximum cycles spent in WAIT before error

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  chunk strobe; one chunk accepted per cycle while high and accepting
in_data  input  CHUNK_W  chunk payload
abort  input  1  synchronous abort of the current pass
cls_done  input  1  classifier single-cycle completion strobe
cls_digit  input  4  classifier result, valid when cls_done=1
image  output  196  assembled image to classifier, held stable outside LOAD
cls_start  output  1  one-cycle start pulse to classifier
busy  output  1  high in LOAD, START and WAIT
result_valid  output  1  digit holds a fresh result
digit  output  4  latched BCD result to seg7
error  output  1  sticky fault flag: timeout or cls_digit > 9
load_count  output  5  chunks accepted so far in the current image

Behaviour:
- Reset (rst=1 at clk edge) values: state=IDLE, image=0, load_count=0, cls_start=0, busy=0, result_valid=0, digit=0, error=0, timer=0.
- States: IDLE, LOAD, START, WAIT.
- Chunk acceptance:
  - A chunk is accepted when in_valid=1 in IDLE or LOAD.
  - Chunk k (0-based) is written to image[7k+6:7k]; load_count increments by 1.
  - in_valid is ignored in START and WAIT. No backpressure exists; the host must not stream in those states.
- IDLE:
  - An accepted chunk goes to image[6:0], sets load_count=1, clears result_valid and error, and moves to LOAD.
  - With NUM_CHUNKS=1, that first chunk moves straight to START.
- LOAD:
  - Waits on in_valid; gaps of any length are allowed.
  - Accepting chunk NUM_CHUNKS-1 (load_count 27 -> 28) moves to START on the next edge.
  - Latency: cls_start is high in the cycle immediately after the last chunk is accepted.
- START:
  - cls_start=1 for exactly this one cycle.
  - Clears timer and moves to WAIT.
  - cls_done in this cycle is ignored.
- WAIT:
  - timer increments each cycle.
  - If cls_done=1: digit<=cls_digit, result_valid<=1, error<=(cls_digit>9), load_count<=0, then IDLE.
  - If timer reaches TIMEOUT without cls_done: error<=1, digit<=4'hE, result_valid<=0, load_count<=0, then IDLE.
  - If cls_done and timeout occur in the same cycle, cls_done wins.
- abort:
  - Effective in any state; takes priority over all other events, including cls_done and chunk accept in the same cycle.
  - Goes to IDLE with load_count=0, cls_start=0, result_valid=0.
  - digit, error and image keep their values.
- busy = (state != IDLE), registered-state decode.
- result_valid and digit persist in IDLE until the next first chunk or abort.
- image is never cleared except by rst. The next load overwrites it chunk by chunk.
- rst mid-operation returns everything to the reset values on that edge, with no classifier start issued.

Test Plan:
- Reset, then 28 consecutive chunks 7'h01..7'h1C -> image[6:0]=7'h01 and image[195:189]=7'h1C; load_count=28; cls_start high exactly one cycle after chunk 28; busy=1.
- Full load; cls_done with cls_digit=4'd7 three cycles after cls_start -> digit=7, result_valid=1, error=0, busy=0, load_count=0; a new chunk afterwards clears result_valid.
- 10 chunks with 2-cycle gaps, abort asserted on the same cycle as chunk 11 -> load_count=0, IDLE, chunk 11 not written; next full load completes normally.
- Full load with no cls_done -> after TIMEOUT (1023) cycles in WAIT, error=1, digit=4'hE, result_valid=0, IDLE.
- Full load, cls_done with cls_digit=4'd12 -> digit=12, result_valid=1, error=1. Separately, cls_done in the START cycle is ignored and the block stays in WAIT.
- rst asserted mid-LOAD (load_count=15) and separately in WAIT -> all outputs return to reset values; the next load starts at image[6:0].
